// File: rtl/sn_pkg.sv
// sn_pkg: shared state encoding and default 10010 pattern for the serial sequence path
package sn_pkg;
  localparam int SN_PAT_W = 5;
  localparam logic [SN_PAT_W-1:0] SN_PAT_10010 = 5'b10010;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/sn_pattern_tx.sv
// sn_pattern_tx: shifts PAT out MSB first rep_i times with gap_i zero bits between reps; ports clk/rst_n, start_i/rep_i/gap_i/abort_i in, sn_o/sn_vld_o/busy_o/done_o registered out
module sn_pattern_tx
  import sn_pkg::*;
#(
  parameter int                PAT_W = SN_PAT_W,
  parameter logic [PAT_W-1:0]  PAT   = SN_PAT_10010,
  parameter int                REP_W = 8,
  parameter int                GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [REP_W-1:0] rep_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             abort_i,
  output logic             sn_o,
  output logic             sn_vld_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] LAST = IW'(PAT_W - 1);
  state_e           state_q, state_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
  logic             sn_d, vld_d, busy_d, done_d;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        rep_d   = rep_i;
        gap_d   = gap_i;
        bit_d   = LAST;
        state_d = (rep_i != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: if (abort_i) state_d = ST_IDLE;
        else if (bit_q != '0) bit_d = bit_q - 1'b1;
        else begin
          rep_d   = rep_q - 1'b1;
          bit_d   = LAST;
          gcnt_d  = gap_q;
          state_d = (rep_q == REP_W'(1)) ? ST_DONE : (gap_q != '0) ? ST_GAP : ST_SHIFT;
        end
      ST_GAP: if (abort_i) state_d = ST_IDLE;
        else begin
          gcnt_d  = gcnt_q - 1'b1;
          state_d = (gcnt_q == GAP_W'(1)) ? ST_SHIFT : ST_GAP;
        end
      default: state_d = ST_IDLE;
    endcase
    sn_d   = (state_d == ST_SHIFT) && PAT[bit_d];
    vld_d  = (state_d == ST_SHIFT) || (state_d == ST_GAP);
    busy_d = state_d != ST_IDLE;
    done_d = state_d == ST_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      gcnt_q   <= '0;
      sn_o     <= 1'b0;
      sn_vld_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
      sn_o     <= sn_d;
      sn_vld_o <= vld_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
    end
endmodule

// File: tb/tb_sn_pattern_tx.sv
// tb_sn_pattern_tx: directed scoreboard bench for sn_pattern_tx
module tb_sn_pattern_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] rep_i = '0;
  logic [3:0] gap_i = '0;
  logic       abort_i = 1'b0;
  logic       sn_o, sn_vld_o, busy_o, done_o;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic [4:0] pat = 5'b10010;
  sn_pattern_tx dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .rep_i(rep_i), .gap_i(gap_i),
    .abort_i(abort_i), .sn_o(sn_o), .sn_vld_o(sn_vld_o), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] obs();
    return {busy_o, sn_vld_o, sn_o, done_o};
  endfunction
  task automatic check(input string tag, input logic [3:0] o, input logic [3:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed{busy,vld,sn,done}=%b expected=%b", tag, o, e);
    end
  endtask
  task automatic build(input int r, input int g);
    exp_q.delete();
    for (int k = 0; k < r; k++) begin
      for (int b = 4; b >= 0; b--) exp_q.push_back({1'b1, 1'b1, pat[b], 1'b0});
      if (k < r - 1) for (int j = 0; j < g; j++) exp_q.push_back(4'b1100);
    end
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0000);
  endtask
  task automatic launch(input int r, input int g);
    @(negedge clk);
    rep_i = 8'(r);
    gap_i = 4'(g);
    start_i = 1'b1;
    build(r, g);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask
  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check(tag, obs(), exp_q.pop_front());
    end
  endtask
  initial begin
    #12;
    check("reset", obs(), 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) check("idle", obs(), 4'b0000);
    launch(1, 0); drain("r1g0");
    launch(2, 0); drain("r2g0");
    launch(0, 3); drain("r0");
    // start held high for a whole frame: only accepted again once back in idle
    @(negedge clk);
    rep_i = 8'd3; gap_i = 4'd2; start_i = 1'b1;
    build(3, 2);
    @(posedge clk);
    drain("r3g2_hold");
    @(negedge clk) check("hold_restart", obs(), 4'b1110);
    start_i = 1'b0; abort_i = 1'b1;
    @(posedge clk) #1 abort_i = 1'b0;
    @(negedge clk) check("hold_abort", obs(), 4'b0000);
    // abort on the 3rd bit of rep 2
    launch(4, 1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("r4g1_pre_abort", obs(), exp_q.pop_front());
    end
    abort_i = 1'b1;
    @(posedge clk) #1 abort_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_abort", obs(), 4'b0000);
    end
    // asynchronous reset mid-frame
    launch(2, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pre_rst", obs(), exp_q.pop_front());
    end
    #2 rst_n = 1'b0;
    #1 check("async_rst", obs(), 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst", obs(), 4'b0000);
    end
    launch(255, 15); drain("r255g15");
    @(negedge clk) check("final_idle", obs(), 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
